// File: rtl/aes_pkg.sv
// Shared types and constants for the S-box arbiter slice.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sbox_arb_state_t;

    typedef enum logic {
        SEL_STATE = 1'b0,
        SEL_KEY   = 1'b1
    } sbox_sel_t;

    localparam int STATE_BYTES = 16;
    localparam int WORD_BYTES  = 4;

    // Index of the final beat for a job of n_bytes over n_lanes lanes.
    function automatic logic [3:0] last_beat(input int n_bytes, input int n_lanes);
        return 4'(n_bytes / n_lanes - 1);
    endfunction

endpackage

// File: rtl/s_box_lookup.sv
// Combinational AES forward S-box, one byte in, one byte out.
module s_box_lookup (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row-major table, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[(11'd2047 - {in_byte, 3'b000}) -: 8];

endmodule

// File: rtl/sbox_arbiter.sv
// Arbitrates SubBytes and SubWord jobs onto a shared bank of N_LANES S-boxes,
// one job in flight, results returned through per-requester output registers.
module sbox_arbiter
    import aes_pkg::*;
#(
    parameter int N_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         state_req,
    input  logic [127:0] state_in,
    output logic         state_ack,
    output logic         state_done,
    output logic [127:0] state_out,
    input  logic         key_req,
    input  logic [31:0]  key_in,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic         busy
);

    localparam int         LANE_SHIFT = $clog2(N_LANES);
    localparam logic [3:0] LAST_S     = last_beat(STATE_BYTES, N_LANES);
    localparam logic [3:0] LAST_K     = last_beat(WORD_BYTES, N_LANES);

    sbox_arb_state_t fsm_r, fsm_next_s;
    sbox_sel_t       sel_r, last_grant_r, grant_sel_s;
    logic [3:0]      beat_cnt_r, beats_last_r, base_s;
    logic [127:0]    buf_r, buf_next_s, state_out_r;
    logic [31:0]     key_out_r;
    logic            grant_any_s, accept_s, sub_last_s;
    logic [7:0]      lane_in_s  [N_LANES];
    logic [7:0]      lane_out_s [N_LANES];

    assign base_s     = beat_cnt_r << LANE_SHIFT;
    assign accept_s   = (fsm_r == IDLE) && grant_any_s && !rst;
    assign sub_last_s = (fsm_r == SUB) && (beat_cnt_r == beats_last_r);

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        assign lane_in_s[l] = buf_r[{base_s + 4'(l), 3'b000} +: 8];
        s_box_lookup u_sbox (
            .in_byte  (lane_in_s[l]),
            .out_byte (lane_out_s[l])
        );
    end

    // Round-robin grant; on a tie the side not served last wins.
    always_comb begin
        grant_any_s = state_req | key_req;
        if (state_req && key_req) begin
            if (last_grant_r == SEL_STATE) grant_sel_s = SEL_KEY;
            else                           grant_sel_s = SEL_STATE;
        end else if (key_req) begin
            grant_sel_s = SEL_KEY;
        end else begin
            grant_sel_s = SEL_STATE;
        end
    end

    // Merge this beat's lane results into the buffer image.
    always_comb begin
        buf_next_s = buf_r;
        if (fsm_r == SUB) begin
            for (int l = 0; l < N_LANES; l++) begin
                buf_next_s[{base_s + 4'(l), 3'b000} +: 8] = lane_out_s[l];
            end
        end else begin
            buf_next_s = buf_r;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_next_s = fsm_r;
        case (fsm_r)
            IDLE:    fsm_next_s = accept_s   ? SUB  : IDLE;
            SUB:     fsm_next_s = sub_last_s ? DONE : SUB;
            DONE:    fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) fsm_r <= IDLE;
        else     fsm_r <= fsm_next_s;
    end

    // Job capture, beat sequencing and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r        <= SEL_STATE;
            last_grant_r <= SEL_STATE;
            beat_cnt_r   <= 4'd0;
            beats_last_r <= 4'd0;
            buf_r        <= 128'd0;
            state_out_r  <= 128'd0;
            key_out_r    <= 32'd0;
        end else begin
            if (accept_s) begin
                sel_r        <= grant_sel_s;
                last_grant_r <= grant_sel_s;
                beat_cnt_r   <= 4'd0;
                beats_last_r <= (grant_sel_s == SEL_KEY) ? LAST_K : LAST_S;
                buf_r        <= (grant_sel_s == SEL_KEY) ? {96'd0, key_in} : state_in;
            end else if (fsm_r == SUB) begin
                buf_r      <= buf_next_s;
                beat_cnt_r <= beat_cnt_r + 4'd1;
            end
            // Last beat's results bypass the buffer so outputs are valid in DONE.
            if (sub_last_s) begin
                if (sel_r == SEL_KEY) key_out_r   <= buf_next_s[31:0];
                else                  state_out_r <= buf_next_s;
            end
        end
    end

    // Handshake and status outputs.
    always_comb begin
        state_ack  = accept_s && (grant_sel_s == SEL_STATE);
        key_ack    = accept_s && (grant_sel_s == SEL_KEY);
        state_done = (fsm_r == DONE) && (sel_r == SEL_STATE);
        key_done   = (fsm_r == DONE) && (sel_r == SEL_KEY);
        busy       = (fsm_r != IDLE);
        state_out  = state_out_r;
        key_out    = key_out_r;
    end

endmodule
